// File: rtl/ps2_key_tracker_if.sv
// Byte-in / event-out bundle for the PS/2 key tracker.
// The master side is the tracker; the slave side is the byte source and event consumer.
interface ps2_key_tracker_if #(
    parameter int NUM_KEYS = 4,
    parameter int CW       = 4
);
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic [NUM_KEYS-1:0] key_held;
    logic [7:0]          last_ascii;
    logic                evt_valid;
    logic                evt_ready;
    logic [7:0]          evt_code;
    logic                evt_break;
    logic                evt_ext;
    logic [CW-1:0]       evt_count;
    logic                overflow;
    logic                overflow_clr;

    modport master (
        input  rx_data, rx_valid, evt_ready, overflow_clr,
        output key_held, last_ascii, evt_valid, evt_code, evt_break, evt_ext,
               evt_count, overflow
    );

    modport slave (
        output rx_data, rx_valid, evt_ready, overflow_clr,
        input  key_held, last_ascii, evt_valid, evt_code, evt_break, evt_ext,
               evt_count, overflow
    );
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scan-code parser: E0/F0 prefix handling, held-key tracking for mapped keys,
// last-pressed ASCII and a show-ahead event FIFO with sticky overflow.
module ps2_key_tracker #(
    parameter int                    NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = {8'h35, 8'h32, 8'h42, 8'h15},
    parameter logic [NUM_KEYS*8-1:0] KEY_ASCII      = {"y", "b", "k", "q"},
    parameter int                    FIFO_DEPTH     = 8,
    parameter int                    PREFIX_TIMEOUT = 50000
) (
    input  logic             inclock,
    input  logic             resetn,
    ps2_key_tracker_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK} state_t;
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    state_t  state, state_nxt;
    logic    [TW-1:0] to_cnt;
    logic    timeout;
    logic    is_prefix, is_noise;
    logic    emit, emit_brk, emit_ext;

    assign is_prefix = (bus.rx_data == 8'hE0) || (bus.rx_data == 8'hF0);
    assign is_noise  = (bus.rx_data == 8'hAA) || (bus.rx_data == 8'hFA) ||
                       (bus.rx_data == 8'hFE) || (bus.rx_data == 8'hEE) ||
                       (bus.rx_data == 8'h00) || (bus.rx_data == 8'hFF);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign timeout   = (state != S_IDLE) && !bus.rx_valid &&
                       (to_cnt == TW'(PREFIX_TIMEOUT - 1));

    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.rx_valid) begin
            case (state)
                S_IDLE: begin
                    if (bus.rx_data == 8'hE0)      state_nxt = S_EXT;
                    else if (bus.rx_data == 8'hF0) state_nxt = S_BRK;
                end
                S_EXT: begin
                    if (bus.rx_data == 8'hF0)      state_nxt = S_EXTBRK;
                    else if (bus.rx_data != 8'hE0) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end else if (timeout) begin
            state_nxt = S_IDLE;
        end
    end

    always_comb begin
        emit     = 1'b0;
        emit_brk = 1'b0;
        emit_ext = 1'b0;
        if (bus.rx_valid) begin
            case (state)
                S_IDLE:   emit = !is_prefix && !is_noise;
                S_EXT:    begin emit = !is_prefix; emit_ext = 1'b1; end
                S_BRK:    begin emit = !is_prefix; emit_brk = 1'b1; end
                S_EXTBRK: begin emit = !is_prefix; emit_brk = 1'b1; emit_ext = 1'b1; end
                default:  emit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn)                                       to_cnt <= '0;
        else if (state == S_IDLE || bus.rx_valid || timeout) to_cnt <= '0;
        else                                               to_cnt <= to_cnt + TW'(1);
    end

    // Key lookup: descending scan so the lowest matching index is the one left standing.
    logic          hit;
    logic [KW-1:0] hit_idx;
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (KEY_CODES[8*i +: 8] == bus.rx_data) begin
                hit     = 1'b1;
                hit_idx = KW'(i);
            end
        end
    end

    logic [NUM_KEYS-1:0] held_q;
    logic [7:0]          ascii_q;
    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            held_q  <= '0;
            ascii_q <= '0;
        end else if (emit && !emit_ext) begin
            if (emit_brk) begin
                if (hit) held_q[hit_idx] <= 1'b0;
            end else if (hit) begin
                held_q[hit_idx] <= 1'b1;
                ascii_q         <= KEY_ASCII[8*hit_idx +: 8];
            end else begin
                ascii_q <= 8'h00;
            end
        end
    end

    evt_t          mem [FIFO_DEPTH];
    evt_t          head_q, new_evt;
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0] count, remain;
    logic          full, do_pop, do_push, ovf_q;

    assign new_evt = '{ext: emit_ext, brk: emit_brk, code: bus.rx_data};
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = bus.evt_ready && (count != '0);
    assign do_push = emit && (!full || do_pop);
    assign rd_nxt  = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    assign remain  = count - CW'(do_pop);

    always_ff @(posedge inclock) begin
        if (do_push) mem[wr_ptr] <= new_evt;
    end

    // head_q mirrors the show-ahead entry and simply keeps its value once the FIFO drains.
    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_nxt;
            count  <= remain + CW'(do_push);
            if (do_push && remain == '0) head_q <= new_evt;
            else if (remain != '0)       head_q <= mem[rd_nxt];
            if (emit && full && !do_pop) ovf_q <= 1'b1;
            else if (bus.overflow_clr)   ovf_q <= 1'b0;
        end
    end

    assign bus.key_held   = held_q;
    assign bus.last_ascii = ascii_q;
    assign bus.evt_valid  = (count != '0);
    assign bus.evt_code   = head_q.code;
    assign bus.evt_break  = head_q.brk;
    assign bus.evt_ext    = head_q.ext;
    assign bus.evt_count  = count;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: directed scenarios with literal expectations, then random
// byte/ready traffic compared every cycle against a queue-based behavioural model.
module tb_ps2_key_tracker;
    localparam int NK = 4;
    localparam int D  = 8;
    localparam int PT = 20;
    localparam int CW = $clog2(D) + 1;
    localparam logic [NK*8-1:0] CODES = {8'h35, 8'h32, 8'h42, 8'h15};
    localparam logic [NK*8-1:0] ASC   = {"y", "b", "k", "q"};

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    logic inclock = 1'b0;
    logic resetn  = 1'b0;
    always #5 inclock = ~inclock;

    ps2_key_tracker_if #(.NUM_KEYS(NK), .CW(CW)) bus ();

    ps2_key_tracker #(
        .NUM_KEYS(NK), .KEY_CODES(CODES), .KEY_ASCII(ASC),
        .FIFO_DEPTH(D), .PREFIX_TIMEOUT(PT)
    ) dut (
        .inclock(inclock),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [NK*8-1:0] codes_v = CODES;
    logic [NK*8-1:0] asc_v   = ASC;
    bit              m_pre, m_ext, m_brk, m_ovf;
    int              m_idle;
    logic [NK-1:0]   m_held;
    logic [7:0]      m_ascii;
    evt_t            mq[$];
    evt_t            m_head;

    task automatic model_step();
        bit         pop, em;
        evt_t       e;
        logic [7:0] c;
        int         idx;
        if (!resetn) begin
            m_pre = 0; m_ext = 0; m_brk = 0; m_ovf = 0; m_idle = 0;
            m_held = '0; m_ascii = '0; mq.delete(); m_head = '0;
            return;
        end
        pop = bus.evt_ready && (mq.size() != 0);
        em  = 0;
        e   = '0;
        c   = bus.rx_data;
        if (bus.rx_valid) begin
            m_idle = 0;
            if (!m_pre) begin
                if (c == 8'hE0)      begin m_pre = 1; m_ext = 1; end
                else if (c == 8'hF0) begin m_pre = 1; m_brk = 1; end
                else if (!(c inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
                    em = 1; e = '{ext: 1'b0, brk: 1'b0, code: c};
                end
            end else if (!m_brk) begin
                if (c == 8'hF0) m_brk = 1;
                else if (c != 8'hE0) begin
                    em = 1; e = '{ext: 1'b1, brk: 1'b0, code: c};
                    m_pre = 0; m_ext = 0;
                end
            end else begin
                if (c != 8'hE0 && c != 8'hF0) begin
                    em = 1; e = '{ext: m_ext, brk: 1'b1, code: c};
                end
                m_pre = 0; m_ext = 0; m_brk = 0;
            end
        end else if (m_pre) begin
            m_idle++;
            if (m_idle == PT) begin
                m_pre = 0; m_ext = 0; m_brk = 0; m_idle = 0;
            end
        end
        if (em && !e.ext) begin
            idx = -1;
            for (int i = 0; i < NK; i++)
                if (idx < 0 && codes_v[8*i +: 8] == e.code) idx = i;
            if (e.brk) begin
                if (idx >= 0) m_held[idx] = 1'b0;
            end else if (idx >= 0) begin
                m_held[idx] = 1'b1;
                m_ascii     = asc_v[8*idx +: 8];
            end else begin
                m_ascii = 8'h00;
            end
        end
        if (pop) void'(mq.pop_front());
        if (em && mq.size() == D) m_ovf = 1;
        else begin
            if (em) mq.push_back(e);
            if (bus.overflow_clr) m_ovf = 0;
        end
        if (mq.size() != 0) m_head = mq[0];
    endtask

    always @(posedge inclock) begin
        model_step();
        #1;
        chk("key_held",   32'(bus.key_held),   32'(m_held));
        chk("last_ascii", 32'(bus.last_ascii), 32'(m_ascii));
        chk("evt_valid",  32'(bus.evt_valid),  32'(mq.size() != 0));
        chk("evt_count",  32'(bus.evt_count),  32'(mq.size()));
        chk("evt_code",   32'(bus.evt_code),   32'(m_head.code));
        chk("evt_break",  32'(bus.evt_break),  32'(m_head.brk));
        chk("evt_ext",    32'(bus.evt_ext),    32'(m_head.ext));
        chk("overflow",   32'(bus.overflow),   32'(m_ovf));
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        @(negedge inclock);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge inclock);
        bus.rx_valid = 1'b0;
    endtask

    task automatic pop1();
        @(negedge inclock);
        bus.evt_ready = 1'b1;
        @(negedge inclock);
        bus.evt_ready = 1'b0;
    endtask

    task automatic drain();
        @(negedge inclock);
        bus.evt_ready = 1'b1;
        repeat (D + 2) @(negedge inclock);
        bus.evt_ready = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " key_held"},   32'(bus.key_held),   32'h0);
        chk({tag, " last_ascii"}, 32'(bus.last_ascii), 32'h0);
        chk({tag, " evt_valid"},  32'(bus.evt_valid),  32'h0);
        chk({tag, " evt_count"},  32'(bus.evt_count),  32'h0);
        chk({tag, " evt_code"},   32'(bus.evt_code),   32'h0);
        chk({tag, " overflow"},   32'(bus.overflow),   32'h0);
    endtask

    logic [7:0] tbl [14] = '{8'h15, 8'h42, 8'h32, 8'h35, 8'h1C, 8'h75, 8'hE0,
                             8'hF0, 8'hE0, 8'hF0, 8'hAA, 8'h00, 8'hFF, 8'h6B};

    initial begin
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        bus.evt_ready = 1'b0; bus.overflow_clr = 1'b0;
        repeat (2) @(negedge inclock);
        chk_all_zero("reset");
        resetn = 1'b1;

        // make / break of mapped key 0
        send(8'h15);
        chk("t1 held make", 32'(bus.key_held), 32'h1);
        chk("t1 ascii q",   32'(bus.last_ascii), 32'h71);
        send(8'hF0); send(8'h15);
        chk("t1 held brk",  32'(bus.key_held), 32'h0);
        chk("t1 count",     32'(bus.evt_count), 32'd2);
        chk("t1 head0",     32'({bus.evt_ext, bus.evt_break, bus.evt_code}), 32'h015);
        pop1();
        chk("t1 head1",     32'({bus.evt_ext, bus.evt_break, bus.evt_code}), 32'h115);
        pop1();
        chk("t1 empty",     32'(bus.evt_valid), 32'h0);
        chk("t1 hold",      32'({bus.evt_ext, bus.evt_break, bus.evt_code}), 32'h115);

        // extended make / break leaves key state alone
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        chk("t2 count",     32'(bus.evt_count), 32'd2);
        chk("t2 head0",     32'({bus.evt_ext, bus.evt_break, bus.evt_code}), 32'h275);
        chk("t2 held",      32'(bus.key_held), 32'h0);
        chk("t2 ascii",     32'(bus.last_ascii), 32'h71);
        pop1();
        chk("t2 head1",     32'({bus.evt_ext, bus.evt_break, bus.evt_code}), 32'h375);
        pop1();

        // multiple keys, unmapped make clears ascii
        send(8'h42); send(8'h32); send(8'hF0); send(8'h42);
        chk("t3 held",      32'(bus.key_held), 32'h4);
        chk("t3 ascii b",   32'(bus.last_ascii), 32'h62);
        send(8'h1C);
        chk("t3 ascii 0",   32'(bus.last_ascii), 32'h0);
        drain();

        // overflow, full push+pop, clear
        repeat (9) send(8'h15);
        chk("t4 count full", 32'(bus.evt_count), 32'd8);
        chk("t4 overflow",   32'(bus.overflow), 32'h1);
        @(negedge inclock);
        bus.rx_valid = 1'b1; bus.rx_data = 8'h15; bus.evt_ready = 1'b1;
        @(negedge inclock);
        bus.rx_valid = 1'b0; bus.evt_ready = 1'b0;
        chk("t4 count pp",   32'(bus.evt_count), 32'd8);
        chk("t4 ovf pp",     32'(bus.overflow), 32'h1);
        @(negedge inclock); bus.overflow_clr = 1'b1;
        @(negedge inclock); bus.overflow_clr = 1'b0;
        chk("t4 ovf clr",    32'(bus.overflow), 32'h0);
        drain();

        // prefix timeout versus a late-but-valid break
        bus.evt_ready = 1'b1;
        send(8'hF0); send(8'h15); send(8'hF0); send(8'h32);
        send(8'hF0);
        repeat (PT + 2) @(negedge inclock);
        send(8'h15);
        chk("t5 make",       32'(bus.key_held), 32'h1);
        chk("t5 evt",        32'({bus.evt_ext, bus.evt_break, bus.evt_code}), 32'h015);
        send(8'hF0);
        repeat (PT - 6) @(negedge inclock);
        send(8'h15);
        chk("t5 late brk",   32'(bus.key_held), 32'h0);
        chk("t5 brk evt",    32'({bus.evt_ext, bus.evt_break, bus.evt_code}), 32'h115);
        bus.evt_ready = 1'b0;

        // async reset mid-sequence
        send(8'h15); send(8'h42); send(8'hF0);
        @(negedge inclock);
        resetn = 1'b0;
        #1;
        chk_all_zero("t6 async");
        @(negedge inclock);
        resetn = 1'b1;
        send(8'h15);
        chk("t6 make",       32'(bus.key_held), 32'h1);
        chk("t6 count",      32'(bus.evt_count), 32'd1);
        chk("t6 evt",        32'({bus.evt_ext, bus.evt_break, bus.evt_code}), 32'h015);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            @(negedge inclock);
            bus.rx_valid     = ($urandom % 3) == 0;
            bus.rx_data      = tbl[$urandom % 14];
            bus.evt_ready    = ($urandom % 2) == 0;
            bus.overflow_clr = ($urandom % 20) == 0;
            resetn           = ($urandom % 700) != 0;
        end
        @(negedge inclock);
        bus.rx_valid = 1'b0; bus.evt_ready = 1'b0; bus.overflow_clr = 1'b0; resetn = 1'b1;
        repeat (3) @(negedge inclock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
